// File: rtl/hog_sched_pkg.sv
// hog_sched_pkg: shared types and constants for the HOG scale-job scheduler.
// The job descriptor layout is {addr, img0x, img0y, scale_x, scale_y, scale_n}, MSB first.
package hog_sched_pkg;

  localparam int ADDR_W     = 32;
  localparam int IMG_W      = 16;
  localparam int SCALE_W    = 32;
  localparam int HOG_DESC_W = 160;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [IMG_W-1:0]   img0x;
    logic [IMG_W-1:0]   img0y;
    logic [SCALE_W-1:0] scale_x;
    logic [SCALE_W-1:0] scale_y;
    logic [SCALE_W-1:0] scale_n;
  } hog_desc_t;

  // Number of set bits in a channel vector (at most 8 channels).
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + 4'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/hog_sched_fifo.sv
// hog_sched_fifo: synchronous descriptor FIFO with a registered output stage.
// A written entry reaches rd_data one cycle after the write; level counts the
// memory entries plus the output register. flush empties everything.
module hog_sched_fifo #(
  parameter int W     = 160,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic          rd_valid,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  out_q, out_d;
  logic          out_vld_q, out_vld_d;
  logic          wr_ok, pop, load;

  assign level    = cnt_q + LW'(out_vld_q);
  assign full     = (level == LW'(DEPTH));
  assign empty    = (level == '0);
  assign rd_data  = out_q;
  assign rd_valid = out_vld_q;

  // Next-state: write into memory, refill the output register when it empties or is popped.
  always_comb begin
    wr_ok     = wr_en & ~full;
    pop       = rd_en & out_vld_q;
    load      = (cnt_q != '0) & (~out_vld_q | pop);
    wr_ptr_d  = wr_ptr_q + AW'(wr_ok);
    rd_ptr_d  = rd_ptr_q + AW'(load);
    cnt_d     = cnt_q + LW'(wr_ok) - LW'(load);
    out_vld_d = load | (out_vld_q & ~pop);
    out_d     = load ? mem[rd_ptr_q] : out_q;
    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      cnt_d     = '0;
      out_vld_d = 1'b0;
    end
  end

  // Storage array, no reset needed: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  // Pointer, count and output register state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
    end
  end

endmodule

// File: rtl/hog_scale_sched.sv
// hog_scale_sched: queues HOG scale-job descriptors and dispatches them
// round-robin to NUM_CH pipelines, tracking completions and raising a
// batch-done interrupt. Optional per-channel watchdog: HOG_SCHED_TIMEOUT_EN.
//
// Handshake: a descriptor is taken at a rising edge when push_valid=1 and
// push_ready=1 (and abort=0). push_ready reflects only the full state of the
// queue; a dispatch in the same cycle does not open a slot until next cycle.
module hog_scale_sched
  import hog_sched_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int QDEPTH = 8,
  parameter int TO_W   = 24
) (
  input  logic                    aclk,
  input  logic                    arest,
  input  logic                    push_valid,
  output logic                    push_ready,
  input  logic [HOG_DESC_W-1:0]   push_desc,
  input  logic                    abort,
  output logic [NUM_CH-1:0]       ch_start,
  output logic [HOG_DESC_W-1:0]   ch_desc,
  input  logic [NUM_CH-1:0]       ch_done,
  output logic [NUM_CH-1:0]       ch_busy,
  input  logic [TO_W-1:0]         timeout_val,
  input  logic                    irq_clr,
  output logic                    irq_done,
  output logic [NUM_CH-1:0]       err_timeout,
  output logic                    err_spurious,
  output logic [$clog2(QDEPTH):0] q_level,
  output logic [15:0]             done_cnt
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                  fifo_full, fifo_empty, fifo_vld;
  logic [HOG_DESC_W-1:0] fifo_data;

  logic [NUM_CH-1:0]     busy_q, busy_d, busy_left;
  logic [NUM_CH-1:0]     start_q, sel_oh;
  logic [HOG_DESC_W-1:0] desc_q;
  logic [CW-1:0]         ptr_q, sel, cand;
  logic                  found, dispatch;
  logic [NUM_CH-1:0]     done_ok, to_hit;
  logic                  spur, irq_set;
  logic [15:0]           done_cnt_q, done_cnt_d;
  logic                  irq_q, irq_d;
  logic                  spur_q, spur_d;

  hog_sched_fifo #(
    .W     (HOG_DESC_W),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk      (aclk),
    .rst      (arest),
    .flush    (abort),
    .wr_en    (push_valid & ~abort),
    .wr_data  (push_desc),
    .rd_en    (dispatch),
    .rd_data  (fifo_data),
    .rd_valid (fifo_vld),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (q_level)
  );

  // Round-robin pick: first idle channel starting after the last grant.
  always_comb begin
    sel   = ptr_q;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = CW'((int'(ptr_q) + k) % NUM_CH);
      if (!found && !busy_q[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  // Dispatch, completion and interrupt next-state; busy_q is the registered
  // state so a channel freed this cycle is not eligible until the next one.
  always_comb begin
    done_ok    = ch_done & busy_q;
    spur       = |(ch_done & ~busy_q);
    dispatch   = fifo_vld & found & ~abort;
    sel_oh     = dispatch ? (NUM_CH'(1) << sel) : '0;
    busy_left  = busy_q & ~done_ok & ~to_hit;
    busy_d     = busy_left | sel_oh;
    irq_set    = (busy_q != '0) & (busy_left == '0) & fifo_empty & ~dispatch;
    done_cnt_d = done_cnt_q + 16'(popcount8(8'(done_ok)));
    irq_d      = irq_set | (irq_q & ~irq_clr);
    spur_d     = spur | (spur_q & ~irq_clr);
  end

  // Channel ownership, start pulse, descriptor, counters and sticky flags.
  always_ff @(posedge aclk or posedge arest) begin
    if (arest) begin
      busy_q     <= '0;
      start_q    <= '0;
      desc_q     <= '0;
      ptr_q      <= CW'(NUM_CH - 1);
      done_cnt_q <= '0;
      irq_q      <= 1'b0;
      spur_q     <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      start_q    <= sel_oh;
      if (dispatch) begin
        desc_q <= fifo_data;
        ptr_q  <= sel;
      end
      done_cnt_q <= done_cnt_d;
      irq_q      <= irq_d;
      spur_q     <= spur_d;
    end
  end

`ifdef HOG_SCHED_TIMEOUT_EN
  logic [TO_W-1:0]   wd_cnt_q [NUM_CH];
  logic [NUM_CH-1:0] err_to_q;

  // Expiry when this busy cycle brings the count to timeout_val; a done in
  // the same cycle takes precedence and counts as a normal completion.
  always_comb begin
    to_hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (busy_q[i] && !ch_done[i] && (timeout_val != '0) &&
          ((wd_cnt_q[i] + TO_W'(1)) == timeout_val)) begin
        to_hit[i] = 1'b1;
      end
    end
  end

  // Per-channel busy-cycle counters and sticky expiry flags.
  always_ff @(posedge aclk or posedge arest) begin
    if (arest) begin
      for (int i = 0; i < NUM_CH; i++) begin
        wd_cnt_q[i] <= '0;
      end
      err_to_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (sel_oh[i]) begin
          wd_cnt_q[i] <= '0;
        end else if (busy_q[i]) begin
          wd_cnt_q[i] <= wd_cnt_q[i] + TO_W'(1);
        end
      end
      err_to_q <= to_hit | (err_to_q & {NUM_CH{~irq_clr}});
    end
  end

  assign err_timeout = err_to_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^timeout_val;
  assign to_hit         = '0;
  assign err_timeout    = '0;
`endif

  assign push_ready   = ~fifo_full;
  assign ch_start     = start_q;
  assign ch_desc      = desc_q;
  assign ch_busy      = busy_q;
  assign irq_done     = irq_q;
  assign err_spurious = spur_q;
  assign done_cnt     = done_cnt_q;

endmodule

// File: tb/tb_hog_scale_sched.sv
// tb_hog_scale_sched: self-checking bench for hog_scale_sched (NUM_CH=2, QDEPTH=8).
`timescale 1ns/1ps
module tb_hog_scale_sched;
  import hog_sched_pkg::*;

  localparam int NUM_CH = 2;
  localparam int QDEPTH = 8;
  localparam int TO_W   = 24;
  localparam int LW     = $clog2(QDEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic aclk = 1'b0;
  logic arest = 1'b0;
  always #5 aclk = ~aclk;

  logic                  push_valid, push_ready, abort, irq_clr, irq_done, err_spurious;
  logic [HOG_DESC_W-1:0] push_desc, ch_desc;
  logic [NUM_CH-1:0]     ch_start, ch_done, ch_busy, err_timeout;
  logic [TO_W-1:0]       timeout_val;
  logic [LW-1:0]         q_level;
  logic [15:0]           done_cnt;

  hog_scale_sched #(.NUM_CH(NUM_CH), .QDEPTH(QDEPTH), .TO_W(TO_W)) dut (
    .aclk         (aclk),
    .arest        (arest),
    .push_valid   (push_valid),
    .push_ready   (push_ready),
    .push_desc    (push_desc),
    .abort        (abort),
    .ch_start     (ch_start),
    .ch_desc      (ch_desc),
    .ch_done      (ch_done),
    .ch_busy      (ch_busy),
    .timeout_val  (timeout_val),
    .irq_clr      (irq_clr),
    .irq_done     (irq_done),
    .err_timeout  (err_timeout),
    .err_spurious (err_spurious),
    .q_level      (q_level),
    .done_cnt     (done_cnt)
  );

  // ---------------- scoreboard state ----------------
  logic [HOG_DESC_W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int n_starts = 0;
  int irq_rises = 0;
  logic irq_prev = 1'b0;

  task automatic check(input string name, input logic [HOG_DESC_W-1:0] act,
                       input logic [HOG_DESC_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic logic [HOG_DESC_W-1:0] rand_desc();
    hog_desc_t d;
    d.addr    = $urandom();
    d.img0x   = 16'($urandom_range(0, 65535));
    d.img0y   = 16'($urandom_range(0, 65535));
    d.scale_x = $urandom();
    d.scale_y = $urandom();
    d.scale_n = $urandom();
    return d;
  endfunction

  // One descriptor, waiting (bounded) for push_ready; accepted ones are expected at dispatch.
  task automatic push_one(input logic [HOG_DESC_W-1:0] d);
    int waited;
    waited = 0;
    push_valid = 1'b1;
    push_desc  = d;
    while (!push_ready && waited < 200) begin
      step();
      waited++;
    end
    if (!push_ready) begin
      total++;
      bad++;
      $display("FAIL push_wait: got push_ready=0 after %0d cycles expected 1", waited);
    end else begin
      exp_q.push_back(d);
    end
    step();
    push_valid = 1'b0;
  endtask

  // Asynchronous reset raised between edges; outputs must clear before the next edge.
  task automatic reset_dut();
    @(posedge aclk);
    #2;
    arest = 1'b1;
    #1;
    check("rst_push_ready", push_ready, 1);
    check("rst_ch_start", ch_start, 0);
    check("rst_ch_desc", ch_desc, 0);
    check("rst_ch_busy", ch_busy, 0);
    check("rst_irq_done", irq_done, 0);
    check("rst_err_timeout", err_timeout, 0);
    check("rst_err_spurious", err_spurious, 0);
    check("rst_q_level", q_level, 0);
    check("rst_done_cnt", done_cnt, 0);
    exp_q.delete();
    push_valid = 1'b0;
    abort = 1'b0;
    ch_done = '0;
    irq_clr = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    arest = 1'b0;
    irq_rises = 0;
  endtask

  // Monitor: every start pulse must be one-hot and carry the next expected descriptor.
  always @(negedge aclk) begin
    logic [HOG_DESC_W-1:0] e;
    if (!arest && ch_start != '0) begin
      n_starts++;
      check("start_onehot", $onehot(ch_start), 1);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_start: got ch_start=%b expected no start", ch_start);
      end else begin
        e = exp_q.pop_front();
        check("ch_desc", ch_desc, e);
      end
    end
    if (!arest && irq_done && !irq_prev) irq_rises++;
    irq_prev = irq_done;
  end

  // ---------------- table of per-cycle vectors ----------------
  typedef struct {
    logic                  push_v;
    logic [HOG_DESC_W-1:0] desc;
    logic [NUM_CH-1:0]     exp_start;
    logic [LW-1:0]         exp_level;
  } vec_t;
  vec_t vecs[5];

  logic [HOG_DESC_W-1:0] d9;
  int s0;
  int waited;

  initial begin
    push_valid = 1'b0;
    push_desc = '0;
    abort = 1'b0;
    ch_done = '0;
    irq_clr = 1'b0;
    timeout_val = '0;

    vecs[0] = '{1'b1, rand_desc(), 2'b00, 4'd1};
    vecs[1] = '{1'b1, rand_desc(), 2'b00, 4'd2};
    vecs[2] = '{1'b1, rand_desc(), 2'b01, 4'd2};
    vecs[3] = '{1'b0, '0,          2'b10, 4'd1};
    vecs[4] = '{1'b0, '0,          2'b00, 4'd1};

    // ---- 1: three pushes, two dispatches, one left queued ----
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      push_valid = vecs[i].push_v;
      push_desc  = vecs[i].desc;
      if (vecs[i].push_v) exp_q.push_back(vecs[i].desc);
      step();
      check($sformatf("s1_start_%0d", i), ch_start, vecs[i].exp_start);
      check($sformatf("s1_level_%0d", i), q_level, vecs[i].exp_level);
    end
    push_valid = 1'b0;
    check("s1_busy", ch_busy, 2'b11);
    check("s1_left_queued", exp_q.size(), 1);

    // ---- 2: fill the queue, ninth push held until a done frees a slot ----
    reset_dut();
    push_one(rand_desc());
    push_one(rand_desc());
    steps(3);
    check("s2_busy", ch_busy, 2'b11);
    for (int i = 0; i < 8; i++) push_one(rand_desc());
    check("s2_level_full", q_level, 8);
    check("s2_ready_full", push_ready, 0);
    d9 = rand_desc();
    push_valid = 1'b1;
    push_desc  = d9;
    steps(3);
    check("s2_level_held", q_level, 8);
    check("s2_ready_held", push_ready, 0);
    ch_done = 2'b01;
    step();
    ch_done = '0;
    check("s2_done_cnt", done_cnt, 1);
    step();
    check("s2_redispatch", ch_start, 2'b01);
    check("s2_level_after_pop", q_level, 7);
    check("s2_ready_after_pop", push_ready, 1);
    exp_q.push_back(d9);
    step();
    push_valid = 1'b0;
    check("s2_level_refill", q_level, 8);
    check("s2_ready_refill", push_ready, 0);
    check("s2_exp_left", exp_q.size(), 8);

    // ---- 3: four-job batch, irq once, clear coinciding with set ----
    reset_dut();
    for (int i = 0; i < 4; i++) push_one(rand_desc());
    steps(2);
    check("s3_busy", ch_busy, 2'b11);
    check("s3_level", q_level, 2);
    ch_done = 2'b01;
    step();
    ch_done = '0;
    check("s3_cnt1", done_cnt, 1);
    step();
    check("s3_start_ch0", ch_start, 2'b01);
    ch_done = 2'b10;
    step();
    ch_done = '0;
    step();
    check("s3_start_ch1", ch_start, 2'b10);
    check("s3_level_empty", q_level, 0);
    check("s3_irq_early", irq_done, 0);
    check("s3_cnt2", done_cnt, 2);
    ch_done = 2'b11;
    irq_clr = 1'b1;
    step();
    ch_done = '0;
    irq_clr = 1'b0;
    check("s3_irq_set_wins", irq_done, 1);
    check("s3_cnt4", done_cnt, 4);
    check("s3_busy_idle", ch_busy, 0);
    steps(2);
    check("s3_irq_level", irq_done, 1);
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    check("s3_irq_cleared", irq_done, 0);
    check("s3_irq_rises", irq_rises, 1);
    check("s3_exp_left", exp_q.size(), 0);

    // ---- 4: done on an idle channel ----
    ch_done = 2'b10;
    step();
    ch_done = '0;
    check("s4_spurious", err_spurious, 1);
    check("s4_cnt_same", done_cnt, 4);
    check("s4_busy", ch_busy, 0);
    check("s4_no_irq", irq_done, 0);
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    check("s4_spurious_clr", err_spurious, 0);

    // ---- 5: watchdog on channel 0 ----
    reset_dut();
    timeout_val = 24'd100;
    for (int i = 0; i < 3; i++) push_one(rand_desc());
    waited = 0;
    while (ch_start[0] !== 1'b1 && waited < 10) begin
      step();
      waited++;
    end
    check("s5_first_start", ch_start, 2'b01);
    steps(99);
    check("s5_busy_99", ch_busy[0], 1);
`ifdef HOG_SCHED_TIMEOUT_EN
    step();
    check("s5_busy_100", ch_busy[0], 0);
    check("s5_err_to", err_timeout, 2'b01);
    check("s5_cnt", done_cnt, 0);
    step();
    check("s5_reuse_ch0", ch_start, 2'b01);
    check("s5_err_to_both", err_timeout, 2'b11);
    check("s5_exp_left", exp_q.size(), 0);
`else
    step();
    check("s5_busy_kept", ch_busy, 2'b11);
    check("s5_no_err_to", err_timeout, 0);
    step();
    check("s5_no_start", ch_start, 0);
    check("s5_exp_left", exp_q.size(), 1);
`endif
    timeout_val = '0;

    // ---- 6: abort with five jobs queued ----
    reset_dut();
    for (int i = 0; i < 7; i++) push_one(rand_desc());
    check("s6_level5", q_level, 5);
    check("s6_busy", ch_busy, 2'b11);
    s0 = n_starts;
    abort = 1'b1;
    push_valid = 1'b1;
    push_desc = rand_desc();
    step();
    abort = 1'b0;
    push_valid = 1'b0;
    exp_q.delete();
    check("s6_level_flushed", q_level, 0);
    check("s6_ready", push_ready, 1);
    steps(5);
    check("s6_no_more_starts", n_starts, s0);
    check("s6_level_still0", q_level, 0);
    ch_done = 2'b11;
    step();
    ch_done = '0;
    check("s6_irq", irq_done, 1);
    check("s6_busy_idle", ch_busy, 0);
    check("s6_cnt", done_cnt, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish by 200us expected finish");
    $fatal(1);
  end

endmodule
